// File: rtl/ame_pri_pkg.sv
// Shared types and constants for the 8-bit priority iterator.
package ame_pri_pkg;

  localparam int AME_PRI_W  = 8;
  localparam int AME_PRI_IW = 3;

  typedef enum logic {
    AME_PRI_IDLE = 1'b0,
    AME_PRI_BUSY = 1'b1
  } ame_pri_state_e;

endpackage

// File: rtl/ame_pri_sel_8b.sv
// Combinational pick of the first set bit in scan order, plus a flag
// telling whether anything is left once that bit is removed.
module ame_pri_sel_8b
  import ame_pri_pkg::*;
(
  input  logic [AME_PRI_W-1:0]  mask_i,
  input  logic                  lsb_first_i,
  output logic [AME_PRI_W-1:0]  onehot_o,
  output logic [AME_PRI_IW-1:0] idx_o,
  output logic                  rest_zero_o
);

  logic found;
  int   j;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    j        = 0;
    for (int i = 0; i < AME_PRI_W; i++) begin
      j = lsb_first_i ? i : (AME_PRI_W - 1 - i);
      if (!found && mask_i[j]) begin
        onehot_o[j] = 1'b1;
        idx_o       = j[AME_PRI_IW-1:0];
        found       = 1'b1;
      end
    end
  end

  // An empty mask reports rest-zero so it terminates after one beat.
  assign rest_zero_o = ((mask_i & ~onehot_o) == '0);

endmodule

// File: rtl/ame_pri_iter_8b.sv
// Accepts an 8-bit mask and emits one beat per set bit in scan order; first beat
// one cycle after acceptance, outputs hold while out_ready_i is low, input blocked while busy.
module ame_pri_iter_8b
  import ame_pri_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [AME_PRI_W-1:0]  in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [AME_PRI_IW-1:0] out_idx_o,
  output logic [AME_PRI_W-1:0]  out_onehot_o,
  output logic                  out_last_o,
  output logic                  out_empty_o
);

  ame_pri_state_e       state_q, state_d;
  logic [AME_PRI_W-1:0] mask_q, mask_d;
  logic                 empty_q, empty_d;

  logic [AME_PRI_W-1:0]  sel_onehot;
  logic [AME_PRI_IW-1:0] sel_idx;
  logic                  sel_rest_zero;
  logic                  busy, in_hs, out_hs;

  ame_pri_sel_8b u_sel (
    .mask_i      (mask_q),
    .lsb_first_i (LSB_FIRST),
    .onehot_o    (sel_onehot),
    .idx_o       (sel_idx),
    .rest_zero_o (sel_rest_zero)
  );

  assign busy   = (state_q == AME_PRI_BUSY);
  assign in_hs  = in_valid_i & in_ready_o;
  assign out_hs = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    empty_d = empty_q;
    if (in_hs) begin
      state_d = AME_PRI_BUSY;
      mask_d  = in_data_i;
      empty_d = (in_data_i == '0);
    end else if (out_hs) begin
      mask_d = mask_q & ~sel_onehot;
      if (sel_rest_zero) begin
        state_d = AME_PRI_IDLE;
        empty_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= AME_PRI_IDLE;
      mask_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      empty_q <= empty_d;
    end
  end

  // Outputs depend only on registered state, so they cannot move during a stall.
  assign in_ready_o   = ~busy;
  assign out_valid_o  = busy;
  assign out_idx_o    = busy ? sel_idx : '0;
  assign out_onehot_o = busy ? sel_onehot : '0;
  assign out_last_o   = busy & sel_rest_zero;
  assign out_empty_o  = busy & empty_q;

endmodule
